// File: rtl/lif_layer_scheduler.sv
// lif_layer_scheduler
//   Time-multiplexes one shared LIF datapath across NEURONS virtual neurons
//   that form one layer. Each timestep it latches the layer's input spikes
//   and configuration. It then fetches every neuron's weight row over a
//   req/ack port and evaluates the datapath once per neuron. The new
//   membrane is written back into internal storage. Finally it publishes
//   the layer spike vector together with a one-cycle done pulse.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   start_i, clear_i      begin a timestep / zero all membranes (IDLE only)
//   in_spikes_i, shift_i, threshold_i
//                         per-timestep inputs, sampled when start is accepted
//   busy_o, done_o        activity flag, end-of-timestep pulse
//   spikes_out_o          layer spikes of the last completed timestep
//   w_req_o, w_addr_o, w_ack_i, w_data_i
//                         weight row fetch port
//   dp_*_o / dp_*_i       shared LIF datapath interface (valid in EVAL)
//   mem_rd_addr_i, mem_rd_data_o
//                         combinational debug read of stored membranes
//
// state | meaning
// IDLE  | waiting for start/clear
// FETCH | w_req high, waiting for the weight row of neuron idx
// EVAL  | datapath evaluates neuron idx, membrane written back on the edge
// DONE  | done pulse, spikes_out already valid
module lif_layer_scheduler #(
    parameter int SYNAPSES       = 32,
    parameter int NEURONS        = 8,
    parameter int MEMBRANE_BITS  = $clog2(SYNAPSES) + 2,
    parameter int THRESHOLD_BITS = MEMBRANE_BITS - 1,
    parameter int IDX_BITS       = (NEURONS > 1) ? $clog2(NEURONS) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start_i,
    input  logic                      clear_i,
    input  logic [SYNAPSES-1:0]       in_spikes_i,
    input  logic [2:0]                shift_i,
    input  logic [THRESHOLD_BITS-1:0] threshold_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic [NEURONS-1:0]        spikes_out_o,
    output logic                      w_req_o,
    output logic [IDX_BITS-1:0]       w_addr_o,
    input  logic                      w_ack_i,
    input  logic [SYNAPSES-1:0]       w_data_i,
    output logic [SYNAPSES-1:0]       dp_inputs_o,
    output logic [SYNAPSES-1:0]       dp_weights_o,
    output logic [2:0]                dp_shift_o,
    output logic [THRESHOLD_BITS-1:0] dp_threshold_o,
    output logic [MEMBRANE_BITS-1:0]  dp_last_membrane_o,
    input  logic [MEMBRANE_BITS-1:0]  dp_new_membrane_i,
    input  logic                      dp_is_spike_i,
    input  logic [IDX_BITS-1:0]       mem_rd_addr_i,
    output logic [MEMBRANE_BITS-1:0]  mem_rd_data_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EVAL  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [IDX_BITS-1:0] LAST_IDX  = IDX_BITS'(NEURONS - 1);
    localparam logic [IDX_BITS:0]   NEURONS_W = (IDX_BITS + 1)'(NEURONS);

    state_t                      state_q;
    logic [IDX_BITS-1:0]         idx_q;
    logic                        busy_q;
    logic                        done_q;
    logic                        w_req_q;
    logic [NEURONS-1:0]          spikes_out_q;
    logic [NEURONS-1:0]          spike_acc_q;
    logic [NEURONS-1:0]          spike_acc_d;
    logic [SYNAPSES-1:0]         inputs_q;
    logic [SYNAPSES-1:0]         weights_q;
    logic [2:0]                  shift_q;
    logic [THRESHOLD_BITS-1:0]   threshold_q;
    logic [MEMBRANE_BITS-1:0]    mem_q [NEURONS];

    // Accumulator including the spike being produced this cycle, so the last
    // neuron's result can go straight to spikes_out on its EVAL edge.
    always_comb begin
        spike_acc_d        = spike_acc_q;
        spike_acc_d[idx_q] = dp_is_spike_i;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            w_req_q      <= 1'b0;
            spikes_out_q <= '0;
            spike_acc_q  <= '0;
            inputs_q     <= '0;
            weights_q    <= '0;
            shift_q      <= '0;
            threshold_q  <= '0;
            for (int i = 0; i < NEURONS; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (clear_i) begin
                        for (int i = 0; i < NEURONS; i++) begin
                            mem_q[i] <= '0;
                        end
                    end
                    if (start_i) begin
                        inputs_q    <= in_spikes_i;
                        shift_q     <= shift_i;
                        threshold_q <= threshold_i;
                        idx_q       <= '0;
                        spike_acc_q <= '0;
                        busy_q      <= 1'b1;
                        w_req_q     <= 1'b1;
                        state_q     <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (w_ack_i) begin
                        weights_q <= w_data_i;
                        w_req_q   <= 1'b0;
                        state_q   <= S_EVAL;
                    end
                end
                S_EVAL: begin
                    mem_q[idx_q] <= dp_new_membrane_i;
                    spike_acc_q  <= spike_acc_d;
                    if (idx_q == LAST_IDX) begin
                        spikes_out_q <= spike_acc_d;
                        done_q       <= 1'b1;
                        state_q      <= S_DONE;
                    end else begin
                        idx_q   <= idx_q + 1'b1;
                        w_req_q <= 1'b1;
                        state_q <= S_FETCH;
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    w_req_q <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        mem_rd_data_o = '0;
        if ({1'b0, mem_rd_addr_i} < NEURONS_W) begin
            mem_rd_data_o = mem_q[mem_rd_addr_i];
        end
    end

    assign busy_o             = busy_q;
    assign done_o             = done_q;
    assign spikes_out_o       = spikes_out_q;
    assign w_req_o            = w_req_q;
    assign w_addr_o           = idx_q;
    assign dp_inputs_o        = inputs_q;
    assign dp_weights_o       = weights_q;
    assign dp_shift_o         = shift_q;
    assign dp_threshold_o     = threshold_q;
    assign dp_last_membrane_o = mem_q[idx_q];

endmodule

// File: tb/tb_lif_layer_scheduler.sv
module tb_lif_layer_scheduler;

    localparam int SYN = 32;
    localparam int NEU = 8;
    localparam int MB  = 7;
    localparam int TB  = 6;
    localparam int IB  = 3;

    logic           clk = 1'b0;
    logic           reset;
    logic           start_i, clear_i;
    logic [SYN-1:0] in_spikes_i;
    logic [2:0]     shift_i;
    logic [TB-1:0]  threshold_i;
    logic           busy_o, done_o;
    logic [NEU-1:0] spikes_out_o;
    logic           w_req_o;
    logic [IB-1:0]  w_addr_o;
    logic           w_ack_i;
    logic [SYN-1:0] w_data_i;
    logic [SYN-1:0] dp_inputs_o, dp_weights_o;
    logic [2:0]     dp_shift_o;
    logic [TB-1:0]  dp_threshold_o;
    logic [MB-1:0]  dp_last_membrane_o;
    logic [MB-1:0]  dp_new_membrane_i;
    logic           dp_is_spike_i;
    logic [IB-1:0]  mem_rd_addr_i;
    logic [MB-1:0]  mem_rd_data_o;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    lif_layer_scheduler dut (
        .clk                (clk),
        .reset              (reset),
        .start_i            (start_i),
        .clear_i            (clear_i),
        .in_spikes_i        (in_spikes_i),
        .shift_i            (shift_i),
        .threshold_i        (threshold_i),
        .busy_o             (busy_o),
        .done_o             (done_o),
        .spikes_out_o       (spikes_out_o),
        .w_req_o            (w_req_o),
        .w_addr_o           (w_addr_o),
        .w_ack_i            (w_ack_i),
        .w_data_i           (w_data_i),
        .dp_inputs_o        (dp_inputs_o),
        .dp_weights_o       (dp_weights_o),
        .dp_shift_o         (dp_shift_o),
        .dp_threshold_o     (dp_threshold_o),
        .dp_last_membrane_o (dp_last_membrane_o),
        .dp_new_membrane_i  (dp_new_membrane_i),
        .dp_is_spike_i      (dp_is_spike_i),
        .mem_rd_addr_i      (mem_rd_addr_i),
        .mem_rd_data_o      (mem_rd_data_o)
    );

    // Stub datapath: new = last + popcount(inputs & weights), spike = new >= threshold
    always_comb begin
        dp_new_membrane_i = dp_last_membrane_o + MB'($countones(dp_inputs_o & dp_weights_o));
        dp_is_spike_i     = ($signed(dp_new_membrane_i) >= $signed({1'b0, dp_threshold_o}));
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic check_mems(input string tag, input int exp_m [NEU]);
        for (int i = 0; i < NEU; i++) begin
            mem_rd_addr_i = IB'(i);
            #1;
            check($sformatf("%s_mem%0d", tag, i), 32'(mem_rd_data_o), 32'(exp_m[i]));
        end
    endtask

    // One timestep with in_spikes=all ones, shift=1, threshold=2 and
    // w_data = index+1. Inputs are scrambled after the accept cycle.
    task automatic run_step(input logic do_clear, input int delay_n, input int delay_idx,
                            input logic disturb, output int lat, output int hold_cnt,
                            output logic [MB-1:0] last0);
        int  waited;
        int  cyc;
        logic seen0;
        @(negedge clk);
        start_i     = 1'b1;
        clear_i     = do_clear;
        in_spikes_i = '1;
        shift_i     = 3'd1;
        threshold_i = 6'd2;
        @(negedge clk);
        in_spikes_i = '0;
        shift_i     = 3'd0;
        threshold_i = 6'd0;
        cyc = 1; lat = -1; hold_cnt = 0; waited = 0; seen0 = 1'b0; last0 = '1;
        while (cyc <= 200) begin
            if (disturb && cyc == 5) begin
                start_i = 1'b1; clear_i = 1'b1;
            end else begin
                start_i = 1'b0; clear_i = 1'b0;
            end
            if (busy_o && !w_req_o && w_addr_o == 3'd0 && !seen0) begin
                last0 = dp_last_membrane_o;
                seen0 = 1'b1;
            end
            if (busy_o && !w_req_o && w_addr_o == 3'd2) begin
                check("dp_bundle_n2", {dp_inputs_o[3:0], dp_weights_o[7:0], 2'b00, dp_threshold_o, 5'd0, dp_shift_o},
                      {4'hF, 8'h03, 2'b00, 6'd2, 5'd0, 3'd1});
            end
            if (done_o) begin
                lat = cyc;
                break;
            end
            if (w_req_o) begin
                if (int'(w_addr_o) == delay_idx) hold_cnt++;
                if (int'(w_addr_o) == delay_idx && waited < delay_n) begin
                    w_ack_i = 1'b0;
                    waited++;
                end else begin
                    w_ack_i  = 1'b1;
                    w_data_i = 32'(w_addr_o) + 32'd1;
                end
            end else begin
                w_ack_i = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        w_ack_i = 1'b0;
        start_i = 1'b0;
        clear_i = 1'b0;
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        clear_i = 1'b1;
        @(negedge clk);
        clear_i = 1'b0;
    endtask

    // Hand-computed: popcount(i+1) for i=0..7 is 1,1,2,1,2,2,3,1.
    // Threshold 2 -> neurons 2,4,5,6 spike -> 8'h74. Second pass doubles all.
    int mem_zero [NEU] = '{0, 0, 0, 0, 0, 0, 0, 0};
    int mem_s1   [NEU] = '{1, 1, 2, 1, 2, 2, 3, 1};
    int mem_s2   [NEU] = '{2, 2, 4, 2, 4, 4, 6, 2};

    initial begin
        int lat;
        int hold;
        int cyc;
        logic [MB-1:0] last0;

        reset = 1'b1; start_i = 1'b0; clear_i = 1'b0; in_spikes_i = '0;
        shift_i = '0; threshold_i = '0; w_ack_i = 1'b0; w_data_i = '0; mem_rd_addr_i = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        check("rst_ctrl", {busy_o, done_o, w_req_o, w_addr_o}, 6'd0);
        check("rst_spikes", 32'(spikes_out_o), 32'h0);
        check("rst_dp", {dp_inputs_o[15:0], dp_weights_o[15:0]}, 32'h0);
        check("rst_dp_cfg", {dp_shift_o, dp_threshold_o, dp_last_membrane_o}, 32'h0);
        check_mems("rst", mem_zero);

        // 1: baseline timestep
        run_step(1'b0, 0, 4, 1'b0, lat, hold, last0);
        check("s1_latency", 32'(lat), 32'd17);
        check("s1_spikes", 32'(spikes_out_o), 32'h74);
        check_mems("s1", mem_s1);
        @(negedge clk);
        check("s1_done_one_cycle", {done_o, busy_o}, 2'b00);
        check("s1_spikes_hold", 32'(spikes_out_o), 32'h74);

        // 2: repeat without clear
        run_step(1'b0, 0, 4, 1'b0, lat, hold, last0);
        check("s2_latency", 32'(lat), 32'd17);
        check("s2_spikes", 32'(spikes_out_o), 32'hFF);
        check_mems("s2", mem_s2);

        pulse_clear();
        check_mems("clr1", mem_zero);

        // 3: neuron 4 acknowledged after 3 wait cycles
        run_step(1'b0, 3, 4, 1'b0, lat, hold, last0);
        check("s3_latency", 32'(lat), 32'd20);
        check("s3_hold_n4", 32'(hold), 32'd4);
        check("s3_spikes", 32'(spikes_out_o), 32'h74);
        check_mems("s3", mem_s1);

        // 4: start and clear pulsed mid-timestep are ignored
        run_step(1'b0, 0, 4, 1'b1, lat, hold, last0);
        check("s4_latency", 32'(lat), 32'd17);
        check("s4_spikes", 32'(spikes_out_o), 32'hFF);
        check_mems("s4", mem_s2);
        pulse_clear();
        check_mems("clr2", mem_zero);

        // 5: reset during EVAL of neuron 3
        run_step(1'b0, 0, 4, 1'b0, lat, hold, last0);
        check("s5a_spikes", 32'(spikes_out_o), 32'h74);
        @(negedge clk);
        start_i = 1'b1; in_spikes_i = '1; shift_i = 3'd1; threshold_i = 6'd2;
        @(negedge clk);
        start_i = 1'b0;
        cyc = 0;
        while (!(busy_o && !w_req_o && w_addr_o == 3'd3) && cyc < 100) begin
            w_ack_i  = w_req_o;
            w_data_i = 32'(w_addr_o) + 32'd1;
            @(negedge clk);
            cyc++;
        end
        check("s5_reach_eval3", 32'(cyc < 100), 32'd1);
        reset = 1'b1; w_ack_i = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        check("s5_ctrl", {busy_o, done_o, w_req_o}, 3'b000);
        check("s5_spikes", 32'(spikes_out_o), 32'h0);
        check_mems("s5", mem_zero);
        cyc = 0;
        repeat (3) begin
            @(negedge clk);
            if (done_o || busy_o) cyc++;
        end
        check("s5_no_done", 32'(cyc), 32'd0);
        run_step(1'b0, 0, 4, 1'b0, lat, hold, last0);
        check("s5b_latency", 32'(lat), 32'd17);
        check("s5b_spikes", 32'(spikes_out_o), 32'h74);
        check_mems("s5b", mem_s1);

        // 6: start and clear together with nonzero membranes
        run_step(1'b1, 0, 4, 1'b0, lat, hold, last0);
        check("s6_last0", 32'(last0), 32'd0);
        check("s6_latency", 32'(lat), 32'd17);
        check("s6_spikes", 32'(spikes_out_o), 32'h74);
        check_mems("s6", mem_s1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
